// File: rtl/oflow_registration_nch_if.sv
// Candidate beat bus from the score-calculation array into successor registration.
// Channel c occupies bits [c*SCORE_W +: SCORE_W] of cand_score and [c*ID_W +: ID_W] of cand_id.
interface oflow_registration_nch_if #(
    parameter int NUM_CH  = 2,
    parameter int SCORE_W = 16,
    parameter int ID_W    = 12
);
    logic                      cand_valid;
    logic [NUM_CH-1:0]         cand_mask;
    logic [NUM_CH*SCORE_W-1:0] cand_score;
    logic [NUM_CH*ID_W-1:0]    cand_id;
    logic                      cand_last;

    modport master (output cand_valid, cand_mask, cand_score, cand_id, cand_last);
    modport slave  (input  cand_valid, cand_mask, cand_score, cand_id, cand_last);
endinterface

// File: rtl/oflow_registration_nch.sv
// Successor registration: reduces NUM_CH-wide candidate beats to the best two (score, id)
// pairs, allocates a fresh ID when nothing matches well enough, and records the object in a row scoreboard.
module oflow_registration_nch #(
    parameter int NUM_CH  = 2,
    parameter int SCORE_W = 16,
    parameter int ID_W    = 12,
    parameter int FEAT_W  = 64,
    parameter int ROWS    = 32,
    localparam int ROW_W  = $clog2(ROWS)
) (
    input  logic                   clk,
    input  logic                   reset_N,
    input  logic                   start_i,
    input  logic [ROW_W-1:0]       row_i,
    input  logic [FEAT_W-1:0]      feat_i,
    input  logic                   first_frame_i,
    input  logic [SCORE_W-1:0]     new_thresh_i,
    oflow_registration_nch_if.slave cand,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   new_obj_o,
    input  logic                   cr_we_i,
    input  logic [ROW_W-1:0]       cr_row_i,
    input  logic                   cr_ptr_i,
    input  logic                   frame_clear_i,
    input  logic [ROW_W-1:0]       rd_row_i,
    output logic [2*SCORE_W-1:0]   rd_score_o,
    output logic [2*ID_W-1:0]      rd_id_o,
    output logic [FEAT_W-1:0]      rd_feat_o,
    output logic [ID_W-1:0]        rd_final_id_o,
    output logic                   rd_valid_o
);
    typedef enum logic [1:0] {IDLE, ACCUM, WRITE} state_t;

    state_t             state_q;
    logic [SCORE_W-1:0] b0_score_q, b1_score_q, b0_score_d, b1_score_d;
    logic [ID_W-1:0]    b0_id_q, b1_id_q, b0_id_d, b1_id_d;
    logic               any_q, any_d;
    logic [ID_W-1:0]    next_id_q;
    logic               ff_q, done_q, new_obj_q, alloc;
    logic [ROW_W-1:0]   row_q;
    logic [FEAT_W-1:0]  feat_q;

    logic [ROWS-1:0]    valid_q;
    logic [ROWS-1:0]    ptr_mem;
    logic [SCORE_W-1:0] s0_mem [ROWS];
    logic [SCORE_W-1:0] s1_mem [ROWS];
    logic [ID_W-1:0]    i0_mem [ROWS];
    logic [ID_W-1:0]    i1_mem [ROWS];
    logic [FEAT_W-1:0]  feat_mem [ROWS];

    logic [2*SCORE_W-1:0] rd_score_q;
    logic [2*ID_W-1:0]    rd_id_q;
    logic [FEAT_W-1:0]    rd_feat_q;
    logic [ID_W-1:0]      rd_final_id_q;
    logic                 rd_valid_q;

    // Channels are inserted in ascending order with strict compares, so ties keep the earlier entry.
    always_comb begin
        logic [SCORE_W-1:0] cs;
        logic [ID_W-1:0]    ci;
        b0_score_d = b0_score_q;
        b0_id_d    = b0_id_q;
        b1_score_d = b1_score_q;
        b1_id_d    = b1_id_q;
        any_d      = any_q;
        cs         = '0;
        ci         = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cand.cand_valid && cand.cand_mask[c]) begin
                cs    = cand.cand_score[c*SCORE_W +: SCORE_W];
                ci    = cand.cand_id[c*ID_W +: ID_W];
                any_d = 1'b1;
                if (cs < b0_score_d) begin
                    b1_score_d = b0_score_d;
                    b1_id_d    = b0_id_d;
                    b0_score_d = cs;
                    b0_id_d    = ci;
                end else if (cs < b1_score_d) begin
                    b1_score_d = cs;
                    b1_id_d    = ci;
                end
            end
        end
    end

    assign alloc = ff_q || !any_q || (b0_score_q > new_thresh_i);

    always_ff @(posedge clk) begin
        if (!reset_N) begin
            state_q       <= IDLE;
            done_q        <= 1'b0;
            new_obj_q     <= 1'b0;
            next_id_q     <= ID_W'(1);
            valid_q       <= '0;
            b0_score_q    <= '1;
            b1_score_q    <= '1;
            b0_id_q       <= '0;
            b1_id_q       <= '0;
            any_q         <= 1'b0;
            rd_score_q    <= '0;
            rd_id_q       <= '0;
            rd_feat_q     <= '0;
            rd_final_id_q <= '0;
            rd_valid_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            new_obj_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        b0_score_q <= '1;
                        b1_score_q <= '1;
                        b0_id_q    <= '0;
                        b1_id_q    <= '0;
                        any_q      <= 1'b0;
                        state_q    <= first_frame_i ? WRITE : ACCUM;
                    end
                end
                ACCUM: begin
                    b0_score_q <= b0_score_d;
                    b1_score_q <= b1_score_d;
                    b0_id_q    <= b0_id_d;
                    b1_id_q    <= b1_id_d;
                    any_q      <= any_d;
                    if (cand.cand_valid && cand.cand_last) state_q <= WRITE;
                end
                WRITE: begin
                    done_q           <= 1'b1;
                    new_obj_q        <= alloc;
                    valid_q[row_q]   <= 1'b1;
                    state_q          <= IDLE;
                    if (alloc) next_id_q <= (next_id_q == '1) ? ID_W'(1) : next_id_q + ID_W'(1);
                end
                default: state_q <= IDLE;
            endcase
            if (frame_clear_i && state_q == IDLE) valid_q <= '0;

            if (valid_q[rd_row_i]) begin
                rd_score_q    <= {s1_mem[rd_row_i], s0_mem[rd_row_i]};
                rd_id_q       <= {i1_mem[rd_row_i], i0_mem[rd_row_i]};
                rd_feat_q     <= feat_mem[rd_row_i];
                rd_final_id_q <= ptr_mem[rd_row_i] ? i1_mem[rd_row_i] : i0_mem[rd_row_i];
                rd_valid_q    <= 1'b1;
            end else begin
                rd_score_q    <= '0;
                rd_id_q       <= '0;
                rd_feat_q     <= '0;
                rd_final_id_q <= '0;
                rd_valid_q    <= 1'b0;
            end
        end
    end

    // Row write issued last so it overrides a same-row pointer write in the WRITE cycle.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && start_i) begin
            ff_q   <= first_frame_i;
            row_q  <= row_i;
            feat_q <= feat_i;
        end
        if (cr_we_i) ptr_mem[cr_row_i] <= cr_ptr_i;
        if (reset_N && state_q == WRITE) begin
            s0_mem[row_q]   <= alloc ? '0 : b0_score_q;
            s1_mem[row_q]   <= alloc ? '1 : b1_score_q;
            i0_mem[row_q]   <= alloc ? next_id_q : b0_id_q;
            i1_mem[row_q]   <= alloc ? '0 : b1_id_q;
            feat_mem[row_q] <= feat_q;
            ptr_mem[row_q]  <= 1'b0;
        end
    end

    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;
    assign new_obj_o     = new_obj_q;
    assign rd_score_o    = rd_score_q;
    assign rd_id_o       = rd_id_q;
    assign rd_feat_o     = rd_feat_q;
    assign rd_final_id_o = rd_final_id_q;
    assign rd_valid_o    = rd_valid_q;
endmodule
